// File: rtl/alarm_controller_pkg.sv
// rtl/alarm_controller_pkg.sv - shared time field widths, calendar limits and alarm FSM encoding
package alarm_controller_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [1:0] ST_DISARMED = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_RINGING  = 2'd2;
    localparam logic [1:0] ST_SNOOZED  = 2'd3;

    typedef struct packed {
        logic [HOUR_W-1:0] hh;
        logic [MIN_W-1:0]  mm;
    } hhmm_t;

endpackage

// File: rtl/alarm_controller_if.sv
// rtl/alarm_controller_if.sv - time-of-day inputs, alarm controls and alarm status outputs
interface alarm_controller_if;
    import alarm_controller_pkg::*;

    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
    logic [SEC_W-1:0]  second;
    logic              set_en;
    logic [HOUR_W-1:0] set_hour;
    logic [MIN_W-1:0]  set_minute;
    logic              arm;
    logic              snooze;
    logic              dismiss;
    logic [HOUR_W-1:0] alarm_hour;
    logic [MIN_W-1:0]  alarm_minute;
    logic              ringing;
    logic              beep;
    logic [1:0]        snooze_left;

    modport master (
        output hour, minute, second, set_en, set_hour, set_minute, arm, snooze, dismiss,
        input  alarm_hour, alarm_minute, ringing, beep, snooze_left
    );

    modport slave (
        input  hour, minute, second, set_en, set_hour, set_minute, arm, snooze, dismiss,
        output alarm_hour, alarm_minute, ringing, beep, snooze_left
    );

endinterface

// File: rtl/alarm_controller_time_add.sv
// rtl/alarm_controller_time_add.sv - combinational HH:MM + ADD_MIN minutes with hour and day wrap
module time_add_minutes
    import alarm_controller_pkg::*;
#(
    parameter int ADD_MIN = 5
) (
    input  logic [HOUR_W-1:0] hour_in,
    input  logic [MIN_W-1:0]  minute_in,
    output logic [HOUR_W-1:0] hour_out,
    output logic [MIN_W-1:0]  minute_out
);

    logic [MIN_W:0]    m_sum;
    logic [HOUR_W-1:0] h_inc;

    always_comb begin
        m_sum      = {1'b0, minute_in} + (MIN_W+1)'(ADD_MIN);
        h_inc      = hour_in + HOUR_W'(1);
        hour_out   = hour_in;
        minute_out = minute_in;
        if (m_sum >= (MIN_W+1)'(MIN_PER_HOUR)) begin
            minute_out = MIN_W'(m_sum - (MIN_W+1)'(MIN_PER_HOUR));
            hour_out   = (h_inc == HOUR_W'(HOURS_PER_DAY)) ? '0 : h_inc;
        end else begin
            minute_out = MIN_W'(m_sum);
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm FSM with stable time sampling, snooze retargeting, ring timeout and beep
module alarm_controller
    import alarm_controller_pkg::*;
#(
    parameter int RING_CYCLES = 600,
    parameter int BEEP_HALF   = 50,
    parameter int SNOOZE_MIN  = 5,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic             clk,
    input  logic             reset,
    alarm_controller_if.slave bus
);

    localparam int RT_W = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
    localparam int BC_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

    logic [HOUR_W-1:0] s1_h, s2_h, st_h, snz_h_calc;
    logic [MIN_W-1:0]  s1_m, s2_m, st_m, snz_m_calc;
    logic [SEC_W-1:0]  s1_s, s2_s, st_s;
    hhmm_t             alarm_t, snz_t, target;
    logic [1:0]        state, state_nxt, snooze_left, left_nxt;
    logic              match, match_q, fire, snz_load, ring_start, set_valid, ringing;
    logic [RT_W-1:0]   ring_timer;
    logic [BC_W-1:0]   beep_cnt;
    logic              beep_lvl;

    time_add_minutes #(.ADD_MIN(SNOOZE_MIN)) u_snooze_add (
        .hour_in    (st_h),
        .minute_in  (st_m),
        .hour_out   (snz_h_calc),
        .minute_out (snz_m_calc)
    );

    // Ripple-clocked time is trusted only once two back-to-back samples agree.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_h <= '0; s1_m <= '0; s1_s <= '0;
            s2_h <= '0; s2_m <= '0; s2_s <= '0;
            st_h <= '0; st_m <= '0; st_s <= '0;
            match_q <= 1'b0;
        end else begin
            s1_h <= bus.hour; s1_m <= bus.minute; s1_s <= bus.second;
            s2_h <= s1_h;     s2_m <= s1_m;       s2_s <= s1_s;
            if ({s1_h, s1_m, s1_s} == {s2_h, s2_m, s2_s}) begin
                st_h <= s1_h; st_m <= s1_m; st_s <= s1_s;
            end
            match_q <= match;
        end
    end

    assign target    = (state == ST_SNOOZED) ? snz_t : alarm_t;
    assign match     = (st_h == target.hh) && (st_m == target.mm) && (st_s == '0);
    assign fire      = match & ~match_q;
    assign set_valid = bus.set_en && (bus.set_hour < HOUR_W'(HOURS_PER_DAY))
                                  && (bus.set_minute < MIN_W'(MIN_PER_HOUR));

    always_comb begin
        state_nxt  = state;
        left_nxt   = snooze_left;
        snz_load   = 1'b0;
        ring_start = 1'b0;
        if (!bus.arm) begin
            state_nxt = ST_DISARMED;
            left_nxt  = 2'(MAX_SNOOZE);
        end else begin
            case (state)
                ST_DISARMED: state_nxt = ST_ARMED;
                ST_ARMED: begin
                    if (fire) begin
                        state_nxt  = ST_RINGING;
                        ring_start = 1'b1;
                    end
                end
                ST_RINGING: begin
                    // An exhausted snooze budget turns the snooze button into dismiss.
                    if (bus.dismiss || (bus.snooze && snooze_left == 2'd0)) begin
                        state_nxt = ST_ARMED;
                        left_nxt  = 2'(MAX_SNOOZE);
                    end else if (bus.snooze) begin
                        state_nxt = ST_SNOOZED;
                        left_nxt  = snooze_left - 2'd1;
                        snz_load  = 1'b1;
                    end else if (ring_timer == RT_W'(RING_CYCLES - 1)) begin
                        state_nxt = ST_ARMED;
                        left_nxt  = 2'(MAX_SNOOZE);
                    end
                end
                ST_SNOOZED: begin
                    if (bus.dismiss) begin
                        state_nxt = ST_ARMED;
                        left_nxt  = 2'(MAX_SNOOZE);
                    end else if (fire) begin
                        state_nxt  = ST_RINGING;
                        ring_start = 1'b1;
                    end
                end
                default: state_nxt = ST_DISARMED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_DISARMED;
            snooze_left <= 2'(MAX_SNOOZE);
            alarm_t     <= '0;
            snz_t       <= '0;
        end else begin
            state       <= state_nxt;
            snooze_left <= left_nxt;
            if (snz_load)
                snz_t <= {snz_h_calc, snz_m_calc};
            if (set_valid)
                alarm_t <= {bus.set_hour, bus.set_minute};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ring_timer <= '0;
            beep_cnt   <= '0;
            beep_lvl   <= 1'b0;
        end else if (ring_start) begin
            ring_timer <= '0;
            beep_cnt   <= '0;
            beep_lvl   <= 1'b1;
        end else if (state == ST_RINGING) begin
            ring_timer <= ring_timer + RT_W'(1);
            if (beep_cnt == BC_W'(BEEP_HALF - 1)) begin
                beep_cnt <= '0;
                beep_lvl <= ~beep_lvl;
            end else begin
                beep_cnt <= beep_cnt + BC_W'(1);
            end
        end
    end

    assign ringing          = (state == ST_RINGING);
    assign bus.ringing      = ringing;
    assign bus.beep         = ringing & beep_lvl;
    assign bus.alarm_hour   = alarm_t.hh;
    assign bus.alarm_minute = alarm_t.mm;
    assign bus.snooze_left  = snooze_left;

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed and randomized checks of alarm_controller against a behavioural model
module tb_alarm_controller;
    import alarm_controller_pkg::*;

    localparam int RING  = 600;
    localparam int BHALF = 50;
    localparam int SMIN  = 5;
    localparam int MAXS  = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    alarm_controller_if bus();

    alarm_controller #(
        .RING_CYCLES (RING),
        .BEEP_HALF   (BHALF),
        .SNOOZE_MIN  (SMIN),
        .MAX_SNOOZE  (MAXS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: times as seconds-of-day / minutes-of-day, alarm life as flags plus ring age.
    int p1 = 0, p2 = 0, stable_sod = 0;
    int alarm_mod = 0, snooze_mod = 0, ring_age = 0, m_left = MAXS;
    bit match_prev = 0, m_on = 0, m_ring = 0, m_snz = 0;

    task automatic model_reset();
        p1 = 0; p2 = 0; stable_sod = 0;
        alarm_mod = 0; snooze_mod = 0; ring_age = 0; m_left = MAXS;
        match_prev = 0; m_on = 0; m_ring = 0; m_snz = 0;
    endtask

    task automatic model_step();
        int cur_min, tgt;
        bit match, fire;
        cur_min = stable_sod / 60;
        tgt     = m_snz ? snooze_mod : alarm_mod;
        match   = (stable_sod % 60 == 0) && (cur_min == tgt);
        fire    = match && !match_prev;
        if (!bus.arm) begin
            m_on = 0; m_ring = 0; m_snz = 0; m_left = MAXS;
        end else if (!m_on) begin
            m_on = 1;
        end else if (m_ring) begin
            if (bus.dismiss || (bus.snooze && m_left == 0)) begin
                m_ring = 0; m_left = MAXS;
            end else if (bus.snooze) begin
                m_ring = 0; m_snz = 1; m_left--;
                snooze_mod = (cur_min + SMIN) % (24 * 60);
            end else if (ring_age == RING - 1) begin
                m_ring = 0; m_left = MAXS;
            end else begin
                ring_age++;
            end
        end else if (m_snz) begin
            if (bus.dismiss) begin
                m_snz = 0; m_left = MAXS;
            end else if (fire) begin
                m_snz = 0; m_ring = 1; ring_age = 0;
            end
        end else if (fire) begin
            m_ring = 1; ring_age = 0;
        end
        if (bus.set_en && int'(bus.set_hour) < 24 && int'(bus.set_minute) < 60)
            alarm_mod = int'(bus.set_hour) * 60 + int'(bus.set_minute);
        match_prev = match;
        if (p1 == p2) stable_sod = p1;
        p2 = p1;
        p1 = int'(bus.hour) * 3600 + int'(bus.minute) * 60 + int'(bus.second);
    endtask

    always @(posedge clk) begin
        if (!reset) model_reset();
        else        model_step();
        #1;
        check("cyc_ringing",      int'(bus.ringing),      int'(m_ring));
        check("cyc_beep",         int'(bus.beep),         int'(m_ring && ((ring_age / BHALF) % 2 == 0)));
        check("cyc_snooze_left",  int'(bus.snooze_left),  m_left);
        check("cyc_alarm_hour",   int'(bus.alarm_hour),   alarm_mod / 60);
        check("cyc_alarm_minute", int'(bus.alarm_minute), alarm_mod % 60);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        bus.hour = 5'(h); bus.minute = 6'(m); bus.second = 6'(s);
    endtask

    task automatic pulse_set(input int h, input int m);
        bus.set_en = 1'b1; bus.set_hour = 5'(h); bus.set_minute = 6'(m);
        tick();
        bus.set_en = 1'b0;
    endtask

    task automatic pulse_snooze();
        bus.snooze = 1'b1; tick(); bus.snooze = 1'b0;
    endtask

    task automatic pulse_dismiss();
        bus.dismiss = 1'b1; tick(); bus.dismiss = 1'b0;
    endtask

    task automatic wait_ring(input string name, input int maxc);
        int i = 0;
        while (bus.ringing !== 1'b1 && i < maxc) begin
            tick();
            i++;
        end
        check(name, int'(bus.ringing), 1);
    endtask

    task automatic hold_quiet(input string name, input int n);
        int cnt = 0;
        repeat (n) begin
            tick();
            if (bus.ringing) cnt++;
        end
        check(name, cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int on_cnt, events;
        logic prev;
        int pool [8];
        bus.set_en = 0; bus.set_hour = 0; bus.set_minute = 0;
        bus.arm = 0; bus.snooze = 0; bus.dismiss = 0;
        set_time(7, 29, 59);
        tick(3);
        reset = 1'b1;
        tick();
        check("rst_alarm_hour",   int'(bus.alarm_hour), 0);
        check("rst_alarm_minute", int'(bus.alarm_minute), 0);
        check("rst_ringing",      int'(bus.ringing), 0);
        check("rst_beep",         int'(bus.beep), 0);
        check("rst_snooze_left",  int'(bus.snooze_left), 3);

        // Single event at 07:30, beep phase and timeout
        pulse_set(7, 30);
        check("set_hour_load",   int'(bus.alarm_hour), 7);
        check("set_minute_load", int'(bus.alarm_minute), 30);
        bus.arm = 1'b1;
        tick(5);
        set_time(7, 30, 0);
        tick(3);
        check("ring_latency_pre", int'(bus.ringing), 0);
        tick();
        check("ring_latency", int'(bus.ringing), 1);
        check("beep_start",   int'(bus.beep), 1);
        on_cnt = 1; events = 0; prev = 1'b1;
        for (int i = 1; i < 1000; i++) begin
            tick();
            if (bus.ringing && !prev) events++;
            if (bus.ringing) on_cnt++;
            prev = bus.ringing;
            if (i == 50)  check("beep_half1", int'(bus.beep), 0);
            if (i == 100) check("beep_half2", int'(bus.beep), 1);
        end
        check("ring_len",  on_cnt, 600);
        check("one_event", events, 0);

        // Asynchronous reset in the middle of a ring
        pulse_set(7, 32);
        set_time(7, 32, 0);
        wait_ring("t1_ring", 10);
        tick(300);
        @(posedge clk);
        #2;
        reset = 1'b0;
        bus.arm = 1'b0;
        set_time(9, 0, 0);
        #1;
        check("async_rst_ringing", int'(bus.ringing), 0);
        check("async_rst_beep",    int'(bus.beep), 0);
        tick(2);
        reset = 1'b1;
        tick();
        check("post_rst_snooze_left", int'(bus.snooze_left), 3);
        check("post_rst_alarm_hour",  int'(bus.alarm_hour), 0);
        tick(4);
        bus.arm = 1'b1;
        hold_quiet("post_rst_quiet", 5);

        // Snooze across midnight: 23:58 + 5 -> 00:03
        pulse_set(23, 58);
        set_time(23, 57, 30);
        tick(4);
        set_time(23, 58, 0);
        wait_ring("t3_ring", 10);
        tick(2);
        pulse_snooze();
        check("t3_snz_ringing", int'(bus.ringing), 0);
        check("t3_snz_left",    int'(bus.snooze_left), 2);
        set_time(0, 3, 0);
        wait_ring("t3_resnooze_ring", 10);
        pulse_dismiss();
        check("t3_dismiss_ringing", int'(bus.ringing), 0);
        check("t3_dismiss_left",    int'(bus.snooze_left), 3);

        // Snooze budget exhaustion
        set_time(23, 57, 0);
        tick(4);
        set_time(23, 58, 0);
        wait_ring("t4_ring0", 10);
        check("t4_left0", int'(bus.snooze_left), 3);
        for (int k = 0; k < 3; k++) begin
            pulse_snooze();
            check("t4_snz_left", int'(bus.snooze_left), 2 - k);
            check("t4_snz_quiet", int'(bus.ringing), 0);
            set_time(0, 3 + 5 * k, 0);
            wait_ring("t4_resnooze_ring", 10);
        end
        check("t4_left_exhausted", int'(bus.snooze_left), 0);
        pulse_snooze();
        check("t4_final_ringing", int'(bus.ringing), 0);
        check("t4_final_left",    int'(bus.snooze_left), 3);
        set_time(0, 18, 0);
        hold_quiet("t4_no_rering", 20);

        // Ripple glitch passing through 07:30:00 for one clk only
        pulse_set(7, 30);
        set_time(6, 30, 0);
        tick(4);
        set_time(7, 30, 0);
        tick();
        set_time(7, 31, 0);
        hold_quiet("t5_glitch", 20);
        set_time(7, 29, 59);
        tick(4);
        set_time(7, 29, 0);
        tick();
        set_time(7, 30, 0);
        wait_ring("t5_real_ring", 10);
        pulse_dismiss();

        // Out-of-range set values and disarm while snoozed
        pulse_set(24, 10);
        check("t6_bad_hour_h", int'(bus.alarm_hour), 7);
        check("t6_bad_hour_m", int'(bus.alarm_minute), 30);
        pulse_set(5, 60);
        check("t6_bad_min_h", int'(bus.alarm_hour), 7);
        check("t6_bad_min_m", int'(bus.alarm_minute), 30);
        set_time(7, 29, 0);
        tick(4);
        set_time(7, 30, 0);
        wait_ring("t6_ring", 10);
        pulse_snooze();
        bus.arm = 1'b0;
        tick();
        check("t6_disarm_ringing", int'(bus.ringing), 0);
        check("t6_disarm_left",    int'(bus.snooze_left), 3);
        tick(2);
        bus.arm = 1'b1;
        tick(2);
        set_time(7, 35, 0);
        hold_quiet("t6_no_snooze_ring", 20);

        // Randomized traffic around a 12:00 alarm
        pulse_set(12, 0);
        pool = '{11*3600 + 59*60 + 59, 12*3600, 12*3600 + 1, 12*3600 + 5*60,
                 12*3600 + 10*60, 12*3600 + 15*60, 11*3600, 12*3600 + 20*60};
        for (int seg = 0; seg < 300; seg++) begin
            int t, hold;
            t = pool[$urandom_range(0, 7)];
            set_time(t / 3600, (t / 60) % 60, t % 60);
            hold = $urandom_range(1, 30);
            for (int c = 0; c < hold; c++) begin
                bus.snooze  = ($urandom_range(0, 24) == 0);
                bus.dismiss = ($urandom_range(0, 59) == 0);
                bus.set_en  = ($urandom_range(0, 199) == 0);
                bus.set_hour   = ($urandom_range(0, 2) == 0) ? 5'd24 : 5'd12;
                bus.set_minute = ($urandom_range(0, 2) == 0) ? 6'd60 : 6'(5 * $urandom_range(0, 1));
                if (bus.arm && $urandom_range(0, 299) == 0) bus.arm = 1'b0;
                else if (!bus.arm && $urandom_range(0, 4) == 0) bus.arm = 1'b1;
                tick();
            end
        end
        bus.snooze = 0; bus.dismiss = 0; bus.set_en = 0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
